// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch front end with memory handshake, redirect/flush and a prefetch buffer.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] PC_INIT = '0,
  parameter int PC_STEP = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] MASK = ~(STEP - 1'b1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;
  state_t state, next;
  logic [ADDR_W-1:0] fetch_pc, issued;
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic [ADDR_W-1:0] pc_buf [DEPTH];
  logic [DATA_W-1:0] instr_buf [DEPTH];
  logic full, accept, push, pop;
  assign full = count == (AW+1)'(DEPTH);
  assign accept = state == REQ && !mem_busy;
  assign push = state == WAIT && mem_rvalid && !redirect_valid;
  assign pop = out_valid && out_ready && !redirect_valid;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = (!redirect_valid && !full) ? REQ : IDLE;
      REQ:     next = mem_busy ? (redirect_valid ? IDLE : REQ) : (redirect_valid ? DISCARD : WAIT);
      WAIT:    next = mem_rvalid ? IDLE : (redirect_valid ? DISCARD : WAIT);
      DISCARD: next = mem_rvalid ? IDLE : DISCARD;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    mem_req = state == REQ;
    mem_addr = fetch_pc;
    out_valid = count != '0;
    out_pc = out_valid ? pc_buf[head] : '0;
    out_instr = out_valid ? instr_buf[head] : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fetch_pc <= PC_INIT;
      issued <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (accept) issued <= fetch_pc;
      fetch_pc <= redirect_valid ? (redirect_pc & MASK) : accept ? fetch_pc + STEP : fetch_pc;
      head <= redirect_valid ? '0 : head + AW'(pop);
      tail <= redirect_valid ? '0 : tail + AW'(push);
      count <= redirect_valid ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk)
    if (push) begin
      pc_buf[tail] <= issued;
      instr_buf[tail] <= mem_rdata;
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch, backpressure, redirect, busy, wrap and async reset.
module tb_instr_fetch_unit;
  logic clk = 0, reset = 0;
  logic mem_busy = 0, mem_rvalid = 0, redirect_valid = 0, out_ready = 0;
  logic [31:0] mem_rdata = 0, redirect_pc = 0;
  logic mem_req, out_valid, b_mem_req, b_out_valid;
  logic [31:0] mem_addr, out_instr, out_pc, b_mem_addr, b_out_instr, b_out_pc;
  int n_checks = 0, n_fail = 0;
  logic chk2 = 0;
  instr_fetch_unit dut (.clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc));
  instr_fetch_unit #(.PC_INIT(32'hFFFF_FFF8)) dut_b (.clk(clk), .reset(reset), .mem_req(b_mem_req),
    .mem_addr(b_mem_addr), .mem_busy(mem_busy), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_instr(b_out_instr), .out_pc(b_out_pc));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    reset = 0;
    mem_busy = 0; mem_rvalid = 0; redirect_valid = 0;
    step(); step();
    reset = 1;
  endtask
  task automatic serve(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin step(); n++; end
    chk("req_seen", {31'b0, mem_req}, 1);
    chk("mem_addr", mem_addr, a);
    if (chk2) chk("wrap_addr", b_mem_addr, a + 32'hFFFF_FFF8);
    mem_busy = 0; step();
    mem_rvalid = 1; mem_rdata = d; step();
    mem_rvalid = 0;
  endtask
  initial begin
    #2;
    chk("rst_req", {31'b0, mem_req}, 0);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    // basic in-order fetch, plus wraparound on the second instance
    do_reset(); out_ready = 1; chk2 = 1;
    step();
    chk("first_req", {31'b0, mem_req}, 1);
    serve(0, 32'h11);
    chk("t1_v0", {31'b0, out_valid}, 1); chk("t1_pc0", out_pc, 0); chk("t1_i0", out_instr, 32'h11);
    serve(4, 32'h22);
    chk("t1_pc1", out_pc, 4); chk("t1_i1", out_instr, 32'h22);
    serve(8, 32'h33);
    chk("t1_pc2", out_pc, 8); chk("t1_i2", out_instr, 32'h33);
    // backpressure fills the buffer, then one pop frees one slot
    do_reset(); out_ready = 0;
    serve(0, 32'hA0); serve(4, 32'hA1); serve(8, 32'hA2); serve(12, 32'hA3);
    for (int i = 0; i < 5; i++) begin chk("full_noreq", {31'b0, mem_req}, 0); step(); end
    chk("full_pc", out_pc, 0); chk("full_instr", out_instr, 32'hA0);
    out_ready = 1; step(); out_ready = 0;
    chk("pop_pc", out_pc, 4);
    serve(16, 32'hA4);
    for (int i = 0; i < 5; i++) begin chk("refull_noreq", {31'b0, mem_req}, 0); step(); end
    chk("refull_pc", out_pc, 4);
    chk2 = 0;
    // redirect during WAIT, late response must be dropped
    do_reset(); out_ready = 1;
    step(); chk("t3_addr", mem_addr, 0);
    step();
    redirect_valid = 1; redirect_pc = 32'h103; step(); redirect_valid = 0;
    chk("t3_noreq", {31'b0, mem_req}, 0); chk("t3_empty", {31'b0, out_valid}, 0);
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEAD; step(); mem_rvalid = 0;
    chk("t3_dropped", {31'b0, out_valid}, 0);
    serve(32'h100, 32'h77);
    chk("t3_pc", out_pc, 32'h100); chk("t3_instr", out_instr, 32'h77);
    // busy memory holds the request; redirect withdraws it
    do_reset(); out_ready = 1;
    serve(0, 32'h1); serve(4, 32'h2);
    mem_busy = 1; step();
    for (int i = 0; i < 5; i++) begin
      chk("busy_req", {31'b0, mem_req}, 1); chk("busy_addr", mem_addr, 8); step();
    end
    redirect_valid = 1; redirect_pc = 32'h40; step(); redirect_valid = 0; mem_busy = 0;
    chk("wd_noreq", {31'b0, mem_req}, 0);
    step();
    chk("wd_req", {31'b0, mem_req}, 1); chk("wd_addr", mem_addr, 32'h40);
    serve(32'h40, 32'h55);
    chk("wd_pc", out_pc, 32'h40); chk("wd_instr", out_instr, 32'h55);
    // asynchronous reset while WAIT with two entries buffered
    do_reset(); out_ready = 0;
    serve(0, 32'h1); serve(4, 32'h2);
    step(); chk("ar_req", {31'b0, mem_req}, 1);
    step(); chk("ar_valid_pre", {31'b0, out_valid}, 1);
    #2 reset = 0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 0); chk("ar_req0", {31'b0, mem_req}, 0);
    chk("ar_pc", out_pc, 0); chk("ar_addr", mem_addr, 0);
    @(posedge clk); #1 reset = 1;
    step();
    chk("ar_restart_req", {31'b0, mem_req}, 1); chk("ar_restart_addr", mem_addr, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
